// File: rtl/axi_sub_rw_arb.sv
// axi_sub_rw_arb
// Shares one downstream register-access port between the AXI subordinate
// write-request path and read-request path. A grant is held for a whole burst.
// A new grant is chosen only at a burst boundary, and the choice alternates
// between write and read. A beat counter stops a burst that never marks its
// last beat.
//
// Handshake: a requester beat moves when its valid (w_req_dv / r_req_dv) is
// high and the shared downstream stall (hld) is low. In that same cycle the
// requester sees its ack. The requester's hld output mirrors the downstream
// stall only while its side holds the grant. Otherwise that hld output is
// forced high, so an ack can never appear while the matching hld is high.
module axi_sub_rw_arb #(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int UW = 32,
   parameter int IW = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   // write request path
   input  logic            w_req_dv,
   input  logic [AW-1:0]   w_req_addr,
   input  logic [DW-1:0]   w_req_data,
   input  logic [DW/8-1:0] w_req_strb,
   input  logic [UW-1:0]   w_req_user,
   input  logic [IW-1:0]   w_req_id,
   input  logic            w_req_last,
   output logic            w_req_hld,
   output logic            w_ack,
   output logic            w_err,
   // read request path
   input  logic            r_req_dv,
   input  logic [AW-1:0]   r_req_addr,
   input  logic [UW-1:0]   r_req_user,
   input  logic [IW-1:0]   r_req_id,
   input  logic            r_req_last,
   output logic            r_req_hld,
   output logic            r_ack,
   output logic [DW-1:0]   r_rdata,
   output logic            r_err,
   // downstream register-access port
   output logic            dv,
   output logic            write,
   output logic [AW-1:0]   addr,
   output logic [DW-1:0]   wdata,
   output logic [DW/8-1:0] wstrb,
   output logic [UW-1:0]   user,
   output logic [IW-1:0]   id,
   output logic            last,
   input  logic            hld,
   input  logic [DW-1:0]   rdata,
   input  logic            err,
   output logic            arb_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_W = 2'd1,
      GNT_R = 2'd2
   } state_t;

   localparam logic [8:0] MAX_BEATS = 9'd256;

   state_t     state_q, state_d;
   logic       last_was_write_q, last_was_write_d;
   logic [8:0] beat_cnt_q, beat_cnt_d;
   logic [8:0] beat_cnt_inc;

   assign beat_cnt_inc = beat_cnt_q + 9'd1;

   // Read data passes straight through. It is meaningful only while r_ack is high.
   assign r_rdata = rdata;

   // State register, write/read alternation flag and burst beat counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         last_was_write_q <= 1'b0;
         beat_cnt_q       <= 9'd0;
      end else begin
         state_q          <= state_d;
         last_was_write_q <= last_was_write_d;
         beat_cnt_q       <= beat_cnt_d;
      end
   end

   // Next state, downstream mux, and per-side handshake outputs.
   always_comb begin
      state_d          = state_q;
      last_was_write_d = last_was_write_q;
      beat_cnt_d       = beat_cnt_q;
      dv               = 1'b0;
      write            = 1'b0;
      addr             = '0;
      wdata            = '0;
      wstrb            = '0;
      user             = '0;
      id               = '0;
      last             = 1'b0;
      w_req_hld        = 1'b1;
      r_req_hld        = 1'b1;
      w_ack            = 1'b0;
      r_ack            = 1'b0;
      w_err            = 1'b0;
      r_err            = 1'b0;
      arb_err          = 1'b0;

      case (state_q)
         IDLE: begin
            // When both sides ask, the side that did not finish last wins.
            if (w_req_dv && r_req_dv) begin
               state_d = last_was_write_q ? GNT_R : GNT_W;
            end else if (w_req_dv) begin
               state_d = GNT_W;
            end else if (r_req_dv) begin
               state_d = GNT_R;
            end
         end

         GNT_W: begin
            dv        = w_req_dv;
            write     = 1'b1;
            addr      = w_req_addr;
            wdata     = w_req_data;
            wstrb     = w_req_strb;
            user      = w_req_user;
            id        = w_req_id;
            last      = w_req_last;
            w_req_hld = hld;
            if (w_req_dv && !hld) begin
               w_ack = 1'b1;
               w_err = err;
               if (w_req_last) begin
                  state_d          = IDLE;
                  last_was_write_d = 1'b1;
                  beat_cnt_d       = 9'd0;
               end else if (beat_cnt_inc == MAX_BEATS) begin
                  // A burst that never ends is cut off here, so the read side is not starved.
                  arb_err          = 1'b1;
                  state_d          = IDLE;
                  last_was_write_d = 1'b1;
                  beat_cnt_d       = 9'd0;
               end else begin
                  beat_cnt_d = beat_cnt_inc;
               end
            end
         end

         GNT_R: begin
            dv        = r_req_dv;
            write     = 1'b0;
            addr      = r_req_addr;
            user      = r_req_user;
            id        = r_req_id;
            last      = r_req_last;
            r_req_hld = hld;
            if (r_req_dv && !hld) begin
               r_ack = 1'b1;
               r_err = err;
               if (r_req_last) begin
                  state_d          = IDLE;
                  last_was_write_d = 1'b0;
                  beat_cnt_d       = 9'd0;
               end else if (beat_cnt_inc == MAX_BEATS) begin
                  arb_err          = 1'b1;
                  state_d          = IDLE;
                  last_was_write_d = 1'b0;
                  beat_cnt_d       = 9'd0;
               end else begin
                  beat_cnt_d = beat_cnt_inc;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // While reset is asserted, no access and no acknowledgement leaves the
      // block, even in the cycle before the state register clears.
      if (!rst_n) begin
         dv        = 1'b0;
         write     = 1'b0;
         w_req_hld = 1'b1;
         r_req_hld = 1'b1;
         w_ack     = 1'b0;
         r_ack     = 1'b0;
         w_err     = 1'b0;
         r_err     = 1'b0;
         arb_err   = 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_sub_rw_arb.sv
// Directed, table-driven bench for axi_sub_rw_arb.
// Each vector holds the control inputs for one cycle and the expected handshake
// flags for that cycle. Inputs are driven just after the rising edge, and the
// outputs are checked on the falling edge.
module tb_axi_sub_rw_arb;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int UW = 32;
   localparam int IW = 3;

   // Expected flag order: {dv, write, w_req_hld, r_req_hld, w_ack, r_ack, w_err, r_err, arb_err}
   localparam logic [8:0] E_IDLE  = 9'b001100000;
   localparam logic [8:0] E_WACK  = 9'b110110000;
   localparam logic [8:0] E_WERR  = 9'b110110100;
   localparam logic [8:0] E_WGAP  = 9'b010100000;
   localparam logic [8:0] E_RACK  = 9'b101001000;
   localparam logic [8:0] E_RSTL  = 9'b101100000;
   localparam logic [8:0] E_ROVR  = 9'b101001001;

   typedef struct {
      string       name;
      logic [6:0]  ctl;    // {rst_n, w_dv, w_last, r_dv, r_last, hld, err}
      logic [31:0] rd;
      logic [8:0]  exp;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            w_req_dv, w_req_last, w_req_hld, w_ack, w_err;
   logic [AW-1:0]   w_req_addr;
   logic [DW-1:0]   w_req_data;
   logic [DW/8-1:0] w_req_strb;
   logic [UW-1:0]   w_req_user;
   logic [IW-1:0]   w_req_id;
   logic            r_req_dv, r_req_last, r_req_hld, r_ack, r_err;
   logic [AW-1:0]   r_req_addr;
   logic [UW-1:0]   r_req_user;
   logic [IW-1:0]   r_req_id;
   logic [DW-1:0]   r_rdata;
   logic            dv, write, last, hld, err, arb_err;
   logic [AW-1:0]   addr;
   logic [DW-1:0]   wdata, rdata;
   logic [DW/8-1:0] wstrb;
   logic [UW-1:0]   user;
   logic [IW-1:0]   id;

   int n_checks = 0;
   int n_errors = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   axi_sub_rw_arb #(.AW(AW), .DW(DW), .UW(UW), .IW(IW)) dut (
      .clk(clk), .rst_n(rst_n),
      .w_req_dv(w_req_dv), .w_req_addr(w_req_addr), .w_req_data(w_req_data),
      .w_req_strb(w_req_strb), .w_req_user(w_req_user), .w_req_id(w_req_id),
      .w_req_last(w_req_last), .w_req_hld(w_req_hld), .w_ack(w_ack), .w_err(w_err),
      .r_req_dv(r_req_dv), .r_req_addr(r_req_addr), .r_req_user(r_req_user),
      .r_req_id(r_req_id), .r_req_last(r_req_last), .r_req_hld(r_req_hld),
      .r_ack(r_ack), .r_rdata(r_rdata), .r_err(r_err),
      .dv(dv), .write(write), .addr(addr), .wdata(wdata), .wstrb(wstrb),
      .user(user), .id(id), .last(last), .hld(hld), .rdata(rdata), .err(err),
      .arb_err(arb_err)
   );

   function automatic vec_t mk(input string name, input logic [6:0] ctl,
                               input logic [8:0] exp, input logic [31:0] rd = 32'h0);
      vec_t v;
      v.name = name;
      v.ctl  = ctl;
      v.exp  = exp;
      v.rd   = (rd != 32'h0) ? rd : $urandom();
      return v;
   endfunction

   function automatic void check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endfunction

   // Drive one cycle of stimulus, then check the outputs on the falling edge.
   task automatic apply(input vec_t v);
      logic [8:0] got;
      {rst_n, w_req_dv, w_req_last, r_req_dv, r_req_last, hld, err} = v.ctl;
      rdata      = v.rd;
      w_req_addr = $urandom();
      w_req_data = $urandom();
      w_req_strb = 4'($urandom_range(0, 15));
      w_req_user = $urandom();
      w_req_id   = 3'($urandom_range(0, 7));
      r_req_addr = $urandom();
      r_req_user = $urandom();
      r_req_id   = 3'($urandom_range(0, 7));
      @(negedge clk);
      got = {dv, write, w_req_hld, r_req_hld, w_ack, r_ack, w_err, r_err, arb_err};
      check({v.name, "_flags"}, 128'(got), 128'(v.exp));
      check({v.name, "_rdata"}, 128'(r_rdata), 128'(v.rd));
      if (v.exp[8]) begin
         if (v.exp[7])
            check({v.name, "_wpath"}, 128'({addr, wdata, wstrb, user, id, last}),
                  128'({w_req_addr, w_req_data, w_req_strb, w_req_user, w_req_id, w_req_last}));
         else
            check({v.name, "_rpath"}, 128'({addr, wdata, wstrb, user, id, last}),
                  128'({r_req_addr, 32'h0, 4'h0, r_req_user, r_req_id, r_req_last}));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // clock/reset block
      rst_n = 1'b0; hld = 1'b0; err = 1'b0; rdata = '0;
      w_req_dv = 1'b0; w_req_last = 1'b0; r_req_dv = 1'b0; r_req_last = 1'b0;
      w_req_addr = '0; w_req_data = '0; w_req_strb = '0; w_req_user = '0; w_req_id = '0;
      r_req_addr = '0; r_req_user = '0; r_req_id = '0;
      repeat (2) @(posedge clk);
      #1;

      // ctl = {rst_n, w_dv, w_last, r_dv, r_last, hld, err}
      // single 4-beat write burst
      vecs.push_back(mk("rst",       7'b0000000, E_IDLE));
      vecs.push_back(mk("w_req",     7'b1100000, E_IDLE));
      vecs.push_back(mk("w_b1",      7'b1100000, E_WACK));
      vecs.push_back(mk("w_b2",      7'b1100000, E_WACK));
      vecs.push_back(mk("w_b3",      7'b1100000, E_WACK));
      vecs.push_back(mk("w_b4",      7'b1110000, E_WACK));
      vecs.push_back(mk("w_done",    7'b1000000, E_IDLE));
      // simultaneous requests from reset: W, gap, R, then alternate R/W
      vecs.push_back(mk("rst2",      7'b0000000, E_IDLE));
      vecs.push_back(mk("both_req",  7'b1111100, E_IDLE));
      vecs.push_back(mk("both_w",    7'b1111100, E_WACK));
      vecs.push_back(mk("gap1",      7'b1111100, E_IDLE));
      vecs.push_back(mk("both_r",    7'b1111100, E_RACK));
      vecs.push_back(mk("gap2",      7'b1111100, E_IDLE));
      vecs.push_back(mk("alt_w",     7'b1111100, E_WACK));
      vecs.push_back(mk("gap3",      7'b1111100, E_IDLE));
      vecs.push_back(mk("alt_r",     7'b1111100, E_RACK));
      // 3-beat read with a 2-cycle stall on beat 2
      vecs.push_back(mk("rd_req",    7'b1001000, E_IDLE));
      vecs.push_back(mk("rd_b1",     7'b1001000, E_RACK));
      vecs.push_back(mk("rd_stall1", 7'b1001010, E_RSTL, 32'hDEADBEEF));
      vecs.push_back(mk("rd_stall2", 7'b1001010, E_RSTL, 32'hDEADBEEF));
      vecs.push_back(mk("rd_b2",     7'b1001000, E_RACK, 32'hDEADBEEF));
      vecs.push_back(mk("rd_b3",     7'b1001100, E_RACK));
      vecs.push_back(mk("rd_done",   7'b1000000, E_IDLE));
      // write with err on beat 1, and a valid gap that keeps the grant
      vecs.push_back(mk("we_req",    7'b1100000, E_IDLE));
      vecs.push_back(mk("we_b1",     7'b1100001, E_WERR));
      vecs.push_back(mk("we_gap",    7'b1001000, E_WGAP));
      vecs.push_back(mk("we_b2",     7'b1111000, E_WACK));
      vecs.push_back(mk("we_done",   7'b1000000, E_IDLE));
      // reset during beat 2 of a write, then write wins a tie
      vecs.push_back(mk("rm_req",    7'b1100000, E_IDLE));
      vecs.push_back(mk("rm_b1",     7'b1100000, E_WACK));
      vecs.push_back(mk("rm_rst",    7'b0100000, E_IDLE));
      vecs.push_back(mk("rm_both",   7'b1111100, E_IDLE));
      vecs.push_back(mk("rm_w",      7'b1111100, E_WACK));

      foreach (vecs[i]) apply(vecs[i]);

      // Overrun: a read burst that never sets last, while a write is pending.
      // Write finished last, so the read wins the tie.
      apply(mk("ov_req", 7'b1101000, E_IDLE));
      for (int b = 1; b <= 256; b++)
         apply(mk($sformatf("ov_b%0d", b), 7'b1101000, (b == 256) ? E_ROVR : E_RACK));
      apply(mk("ov_idle", 7'b1111000, E_IDLE));
      apply(mk("ov_w",    7'b1110000, E_WACK));
      apply(mk("ov_end",  7'b1000000, E_IDLE));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
